mb_deser: RTL and testbench

Receiving end of the macroblock serial stream. Pops paired {sign, pos} entries from the sign FIFO and the pos FIFO, and rebuilds one parallel macroblock: 64 signs, 64 positions, a size and a slice-end flag. Writes the block into the downstream macroblock buffer with a single-cycle mb_wr. It sits between the sign/pos FIFOs and the macroblock buffer that the serializer side reads.

---
 rtl/mb_pkg.sv | 28 ++
 rtl/mb_stream_join.sv | 28 ++
 rtl/mb_deser.sv | 155 +++++++++++++++
 tb/tb_mb_deser.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mb_pkg.sv
// Shared types and sizes for the macroblock deserializer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mb_pkg;

  localparam int N_COEF = 64;
  localparam int POS_W  = 6;
  localparam int SIZE_W = POS_W + 1;

  typedef logic [POS_W-1:0]  pos_t;
  typedef logic [SIZE_W-1:0] size_t;

  // Entry count at which the coefficient arrays are full.
  localparam size_t CNT_MAX = size_t'(N_COEF);

  // One joined FIFO entry: marker=1 closes the block and sign then means slice_end.
  typedef struct packed {
    logic sign;
    logic marker;
    pos_t pos;
  } mb_entry_t;

  typedef enum logic {
    COLLECT = 1'b0,
    EMIT    = 1'b1
  } mb_state_e;

endpackage

// File: rtl/mb_stream_join.sv
// Joins the sign and pos FIFO heads into one valid/ready entry stream.
// Latency: combinational, zero cycles.
// Backpressure: both FIFOs pop together, only when both are non-empty and ent_rdy_i is high.
module mb_stream_join
  import mb_pkg::*;
(
  input  logic           sign_i,
  input  logic           sign_empty_i,
  input  logic [POS_W:0] pos_i,
  input  logic           pos_empty_i,
  input  logic           ent_rdy_i,
  output logic           ent_vld_o,
  output mb_entry_t      ent_dat_o,
  output logic           sign_rd_o,
  output logic           pos_rd_o
);

  logic pop;

  // An entry exists only when both halves are present; never pop one side alone.
  assign ent_vld_o = ~sign_empty_i & ~pos_empty_i;
  assign pop       = ent_vld_o & ent_rdy_i;
  assign sign_rd_o = pop;
  assign pos_rd_o  = pop;

  assign ent_dat_o = '{sign: sign_i, marker: pos_i[POS_W], pos: pos_i[POS_W-1:0]};

endmodule

// File: rtl/mb_deser.sv
// Rebuilds one parallel macroblock from the paired sign/pos FIFO stream.
// Latency: marker popped on edge N gives mb_wr in cycle N+1 (one idle cycle between blocks).
// Backpressure: mb_afull stalls in EMIT holding all outputs; no FIFO pops while stalled.
// Optional MB_DESER_ERR_EN adds sticky err_ovf (overflow drop / marker while block unwritten).
module mb_deser
  import mb_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          clk_en,
  input  logic                          sign_in,
  input  logic                          sign_empty,
  output logic                          sign_rd,
  input  logic [POS_W:0]                pos_in,
  input  logic                          pos_empty,
  output logic                          pos_rd,
  input  logic                          mb_afull,
  output logic                          mb_wr,
  output logic [0:N_COEF-1]             sign_out,
  output logic [0:N_COEF-1][POS_W-1:0]  pos_out,
  output logic [SIZE_W-1:0]             size_out,
  output logic                          slice_end_out
`ifdef MB_DESER_ERR_EN
  ,
  output logic                          err_ovf
`endif
);

  mb_state_e state_q, state_d;
  size_t     cnt_q, cnt_d;
  size_t     size_q, size_d;
  logic      slice_end_q, slice_end_d;

  logic [0:N_COEF-1]            sign_q;
  logic [0:N_COEF-1][POS_W-1:0] pos_q;

  logic      ent_rdy;
  logic      ent_vld;
  logic      ent_pop;
  mb_entry_t ent;
  logic      ent_wr;
  logic      arr_clr;
  pos_t      wr_idx;

  // Pops are suppressed during reset so the FIFOs keep their contents.
  assign ent_rdy = clk_en & ~rst & (state_q == COLLECT);
  assign ent_pop = ent_vld & ent_rdy;
  assign wr_idx  = cnt_q[POS_W-1:0];

  mb_stream_join u_join (
    .sign_i       (sign_in),
    .sign_empty_i (sign_empty),
    .pos_i        (pos_in),
    .pos_empty_i  (pos_empty),
    .ent_rdy_i    (ent_rdy),
    .ent_vld_o    (ent_vld),
    .ent_dat_o    (ent),
    .sign_rd_o    (sign_rd),
    .pos_rd_o     (pos_rd)
  );

  // Next-state: collect entries until a marker, then emit once the buffer has room.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    slice_end_d = slice_end_q;
    ent_wr      = 1'b0;
    arr_clr     = 1'b0;
    mb_wr       = 1'b0;
    case (state_q)
      COLLECT: begin
        if (ent_pop) begin
          if (ent.marker) begin
            size_d      = cnt_q;
            slice_end_d = ent.sign;
            state_d     = EMIT;
          end else if (cnt_q != CNT_MAX) begin
            // Entries past N_COEF are consumed but not stored; cnt saturates.
            ent_wr = 1'b1;
            cnt_d  = cnt_q + size_t'(1);
          end
        end
      end
      EMIT: begin
        if (clk_en && !mb_afull && !rst) begin
          mb_wr   = 1'b1;
          arr_clr = 1'b1;
          cnt_d   = '0;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  // Control registers: state, entry count, latched size and slice_end.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      size_q      <= '0;
      slice_end_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      slice_end_q <= slice_end_d;
    end
  end

  // Coefficient arrays: clear after each written block so unused slots read 0.
  always_ff @(posedge clk) begin
    if (rst || arr_clr) begin
      sign_q <= '0;
      pos_q  <= '0;
    end else if (ent_wr) begin
      sign_q[wr_idx] <= ent.sign;
      pos_q[wr_idx]  <= ent.pos;
    end
  end

  assign sign_out      = sign_q;
  assign pos_out       = pos_q;
  assign size_out      = size_q;
  assign slice_end_out = slice_end_q;

`ifdef MB_DESER_ERR_EN
  logic err_ovf_q;
  logic ovf_drop;
  logic mkr_in_emit;

  assign ovf_drop    = ent_pop & ~ent.marker & (cnt_q == CNT_MAX);
  assign mkr_in_emit = ent_pop & ent.marker & (state_q == EMIT);

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
    end else if (ovf_drop || mkr_in_emit) begin
      err_ovf_q <= 1'b1;
    end
  end

  // A pop while in EMIT would mean the gating above is broken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!mkr_in_emit);
    end
  end

  assign err_ovf = err_ovf_q;
`endif

endmodule

// File: tb/tb_mb_deser.sv
`timescale 1ns/1ps
module tb_mb_deser;
  import mb_pkg::*;

  logic clk = 1'b0;
  logic rst, clk_en, sign_in, sign_empty, sign_rd, pos_empty, pos_rd;
  logic mb_afull, mb_wr, slice_end_out;
  logic [POS_W:0]               pos_in;
  logic [0:N_COEF-1]            sign_out;
  logic [0:N_COEF-1][POS_W-1:0] pos_out;
  logic [SIZE_W-1:0]            size_out;
`ifdef MB_DESER_ERR_EN
  logic err_ovf;
`endif

  typedef struct packed {
    logic [0:N_COEF-1]            sign;
    logic [0:N_COEF-1][POS_W-1:0] pos;
    logic [SIZE_W-1:0]            size;
    logic                         se;
  } blk_t;

  blk_t           exp_q[$];
  logic           sq[$];
  logic [POS_W:0] pq[$];
  blk_t           mdl;
  int             errors;
  int             checks;
  int             wr_cnt;
  int             cyc_n;
  bit             n_rd, n_prd, n_mkr, n_wr, prev_mkr;
  bit             gate_mode, sign_hold, pos_hold;
  logic           s5[20];
  pos_t           p5[20];

  always #5 clk = ~clk;

  mb_deser dut (
    .clk           (clk),
    .rst           (rst),
    .clk_en        (clk_en),
    .sign_in       (sign_in),
    .sign_empty    (sign_empty),
    .sign_rd       (sign_rd),
    .pos_in        (pos_in),
    .pos_empty     (pos_empty),
    .pos_rd        (pos_rd),
    .mb_afull      (mb_afull),
    .mb_wr         (mb_wr),
    .sign_out      (sign_out),
    .pos_out       (pos_out),
    .size_out      (size_out),
    .slice_end_out (slice_end_out)
`ifdef MB_DESER_ERR_EN
    ,
    .err_ovf       (err_ovf)
`endif
  );

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    sign_in    = (sq.size() > 0) ? sq[0] : 1'b0;
    pos_in     = (pq.size() > 0) ? pq[0] : '0;
    sign_empty = (sq.size() == 0) || sign_hold;
    pos_empty  = (pq.size() == 0) || pos_hold;
  endtask

  task automatic push_data(input logic s, input pos_t p);
    sq.push_back(s);
    pq.push_back({1'b0, p});
    if (mdl.size < N_COEF) begin
      mdl.sign[mdl.size] = s;
      mdl.pos[mdl.size]  = p;
      mdl.size           = mdl.size + 1'b1;
    end
    refresh();
  endtask

  task automatic push_marker(input logic se);
    sq.push_back(se);
    pq.push_back({1'b1, pos_t'(21)});
    mdl.se = se;
    exp_q.push_back(mdl);
    mdl = '0;
    refresh();
  endtask

  // One clock: sample/check at negedge, then update the FIFO model after the edge.
  task automatic cyc();
    blk_t e;
    @(negedge clk);
    n_rd  = (sign_rd === 1'b1);
    n_prd = (pos_rd === 1'b1);
    n_mkr = n_rd && pos_in[POS_W];
    n_wr  = (mb_wr === 1'b1);
    if (rst) begin
      chk("rd_in_rst", sign_rd | pos_rd, 0);
      chk("wr_in_rst", mb_wr, 0);
    end else begin
      chk("rd_pair", sign_rd, pos_rd);
      chk("rd_gate", sign_rd & ~(clk_en & ~sign_empty & ~pos_empty), 0);
      if (!clk_en) chk("wr_gate", mb_wr, 0);
      if (prev_mkr) chk("pop_in_emit", sign_rd, 0);
    end
    if (n_wr) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        chk("wr_unexpected", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_size", size_out, e.size);
        chk("sb_slice_end", slice_end_out, e.se);
        chk("sb_sign", sign_out, e.sign);
        chk("sb_pos", pos_out, e.pos);
      end
    end
    prev_mkr = n_mkr;
    @(posedge clk);
    #1;
    cyc_n++;
    if (n_rd && sq.size() > 0) void'(sq.pop_front());
    if (n_prd && pq.size() > 0) void'(pq.pop_front());
    if (gate_mode) begin
      clk_en    = (cyc_n % 3) != 0;
      sign_hold = 1'($urandom_range(0, 1));
      pos_hold  = 1'($urandom_range(0, 1));
    end
    refresh();
  endtask

  task automatic wait_wr(input string tag, input int budget);
    int start;
    start = wr_cnt;
    for (int i = 0; i < budget && wr_cnt == start; i++) cyc();
    chk(tag, wr_cnt != start, 1);
  endtask

  task automatic wait_mkr(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      cyc();
      seen = n_mkr;
    end
    chk(tag, seen, 1);
  endtask

  initial begin
    errors = 0; checks = 0; wr_cnt = 0; cyc_n = 0;
    prev_mkr = 0; gate_mode = 0; sign_hold = 0; pos_hold = 0;
    mdl = '0;
    rst = 1'b1; clk_en = 1'b1; mb_afull = 1'b0;
    refresh();

    // Reset state
    cyc(); cyc();
    chk("rst_size", size_out, 0);
    chk("rst_slice_end", slice_end_out, 0);
    chk("rst_sign", sign_out, 0);
    chk("rst_pos", pos_out, 0);
    chk("rst_wr", mb_wr, 0);
    rst = 1'b0;
    cyc();

    // 1: single entry then marker; arrays clear after the write
    push_data(1'b1, pos_t'(0));
    push_marker(1'b0);
    wait_mkr("t1_mkr");
    cyc();
    chk("t1_wr_latency", n_wr, 1);
    chk("t1_clr_sign", sign_out, 0);
    chk("t1_clr_pos", pos_out, 0);
    chk("t1_size_hold", size_out, 1);

    // 2: full block, alternating signs 1,0
    for (int i = 0; i < 64; i++) push_data(1'((i % 2) == 0), pos_t'(i));
    push_marker(1'b1);
    chk("t2_sign_model", mdl.size, 0);
    chk("t2_sign_pattern", exp_q[0].sign, 64'hAAAA_AAAA_AAAA_AAAA);
    wait_wr("t2_wr", 300);

    // 3: back-to-back blocks with exactly one idle cycle
    for (int i = 0; i < 17; i++) push_data(1'($urandom_range(0, 1)), pos_t'((2 + 3 * i) % 64));
    push_marker(1'b0);
    push_marker(1'b1);
    wait_mkr("t3_mkr");
    cyc();
    chk("t3_wr1", n_wr, 1);
    chk("t3_idle", n_rd, 0);
    cyc();
    chk("t3_next_pop", n_rd, 1);
    cyc();
    chk("t3_wr2", n_wr, 1);

    // 4: mb_afull stall with another block waiting
    mb_afull = 1'b1;
    push_data(1'b1, pos_t'(9));
    push_data(1'b0, pos_t'(4));
    push_data(1'b1, pos_t'(63));
    push_marker(1'b1);
    push_data(1'b1, pos_t'(1));
    push_marker(1'b0);
    wait_mkr("t4_mkr");
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("t4_no_wr", n_wr, 0);
      chk("t4_no_rd", n_rd, 0);
      chk("t4_size", size_out, 3);
      chk("t4_slice_end", slice_end_out, 1);
      chk("t4_sign0", sign_out[0], 1);
      chk("t4_pos2", pos_out[2], 63);
    end
    mb_afull = 1'b0;
    cyc();
    chk("t4_wr_after", n_wr, 1);
    wait_wr("t4_b2", 50);

    // 5: same block gated by empties/clk_en, then ungated
    for (int i = 0; i < 20; i++) begin
      s5[i] = 1'($urandom_range(0, 1));
      p5[i] = pos_t'($urandom_range(0, 63));
    end
    gate_mode = 1'b1;
    for (int i = 0; i < 20; i++) push_data(s5[i], p5[i]);
    push_marker(1'b1);
    wait_wr("t5_gated", 600);
    gate_mode = 1'b0; clk_en = 1'b1; sign_hold = 1'b0; pos_hold = 1'b0;
    refresh();
    for (int i = 0; i < 20; i++) push_data(s5[i], p5[i]);
    push_marker(1'b1);
    wait_wr("t5_ungated", 100);

    // 6: overflow, then reset mid-block
    for (int i = 0; i < 66; i++) push_data(1'($urandom_range(0, 1)), pos_t'(i % 64));
    push_marker(1'b1);
    wait_wr("t6_wr", 300);
`ifdef MB_DESER_ERR_EN
    chk("t6_err_ovf", err_ovf, 1);
`endif
    for (int i = 0; i < 10; i++) push_data(1'b1, pos_t'(i + 5));
    for (int i = 0; i < 50 && pq.size() > 0; i++) cyc();
    chk("t6_partial_drain", pq.size(), 0);
    rst = 1'b1;
    mdl = '0;
    push_data(1'b1, pos_t'(7));
    push_data(1'b0, pos_t'(8));
    push_data(1'b1, pos_t'(9));
    cyc(); cyc();
    chk("t6_rst_size", size_out, 0);
    chk("t6_rst_slice_end", slice_end_out, 0);
    chk("t6_rst_sign", sign_out, 0);
    chk("t6_rst_pos", pos_out, 0);
    chk("t6_fifo_kept", pq.size(), 3);
`ifdef MB_DESER_ERR_EN
    chk("t6_rst_err", err_ovf, 0);
`endif
    rst = 1'b0;
    push_marker(1'b0);
    wait_wr("t6_after_rst", 50);

    cyc();
    chk("sb_drained", exp_q.size(), 0);
    chk("wr_total", wr_cnt, 10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
